shifter_spi_master: RTL

//  Processor-side SPI master for the barrel-shifter slave. Accepts one shift request per valid/ready handshake,

---
 rtl/shifter_spi_master_pkg.sv | 39 +++
 rtl/shifter_spi_master_spi_shift_reg.sv | 32 +++
 rtl/shifter_spi_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/shifter_spi_master_pkg.sv
// Shared types and constants for the shifter SPI master: operation encoding,
// the wire-level packet layout, link states and derived counter widths.
package shifter_spi_master_pkg;

  localparam int REGISTER_SIZE = 8;
  localparam int SHIFT_WIDTH   = $clog2(REGISTER_SIZE);
  localparam int NSS_WIDTH     = 4;

  typedef enum logic {
    SHL = 1'b0,
    SHR = 1'b1
  } Operation;

  // Bit 0 (op_code) goes out on the wire first.
  typedef struct packed {
    logic [SHIFT_WIDTH-1:0]   shift_amount;
    logic [REGISTER_SIZE-1:0] operand;
    Operation                 op_code;
  } ShifterPacket;

  localparam int PACKET_SIZE = $bits(ShifterPacket);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both the TX and RX phases.
  localparam int BIT_CNT_WIDTH = $clog2(max_int(PACKET_SIZE, REGISTER_SIZE) + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX,
    WAIT_ACK,
    RX,
    DONE
  } ShifterLinkState;

endpackage

// File: rtl/shifter_spi_master_spi_shift_reg.sv
// Parallel-load shift register, LSB first: bit 0 is the next bit out, and a
// serial bit enters at the MSB so the first bit received ends up in bit 0.
module shifter_spi_master_spi_shift_reg
  import shifter_spi_master_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift_en,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  // Load has priority over shifting; the register holds when neither is asserted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift_en) begin
      r_data <= {i_serial_in, r_data[WIDTH-1:1]};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/shifter_spi_master.sv
// Processor-side SPI master for the barrel-shifter slave. One request per
// valid/ready handshake: start bit, packet LSB first, wait for the slave's
// ack, then receive the REGISTER_SIZE-bit result and pulse o_result_valid.
// Optional feature macro: SHIFTER_TIMEOUT_EN (abort WAIT_ACK after
// TimeoutCycles cycles without an ack and pulse o_error).
module shifter_spi_master
  import shifter_spi_master_pkg::*;
#(
  parameter int NssPosition   = 0,
  parameter int TimeoutCycles = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_op_code,
  input  logic [REGISTER_SIZE-1:0] i_operand,
  input  logic [SHIFT_WIDTH-1:0]   i_shift_amount,
  output logic                     o_result_valid,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_error,
  output logic [NSS_WIDTH-1:0]     o_nss,
  output logic                     o_mosi,
  input  logic                     i_miso
);

  ShifterLinkState            r_state;
  ShifterLinkState            w_state_next;
  logic [BIT_CNT_WIDTH-1:0]   r_bit_cnt;
  logic                       w_accept;
  logic                       w_link_active;
  ShifterPacket               w_packet;
  logic [PACKET_SIZE-1:0]     w_tx_data;
  logic [REGISTER_SIZE-1:0]   w_rx_data;
  logic                       w_tx_unused;
  logic                       r_result_valid;
  logic [REGISTER_SIZE-1:0]   r_result;

  assign w_packet = {i_shift_amount, i_operand, i_op_code};

`ifdef SHIFTER_TIMEOUT_EN
  localparam int TO_CNT_WIDTH = $clog2(TimeoutCycles + 1);
  logic [TO_CNT_WIDTH-1:0] r_to_cnt;
  logic                    w_timeout;
  logic                    r_error;
`else
  // Only meaningful when the timeout feature is built in.
  localparam int unused_timeout_cycles = TimeoutCycles;
`endif

  // Next-state logic; the packet is captured only on the accept cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
`ifdef SHIFTER_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
        end
      end
      START: w_state_next = TX;
      TX: begin
        if (r_bit_cnt == BIT_CNT_WIDTH'(PACKET_SIZE - 1)) w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_miso) begin
          w_state_next = RX;
        end
`ifdef SHIFTER_TIMEOUT_EN
        else if (r_to_cnt == TO_CNT_WIDTH'(TimeoutCycles - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
`endif
      end
      RX: begin
        if (r_bit_cnt == BIT_CNT_WIDTH'(REGISTER_SIZE - 1)) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register and bit counter; the counter restarts on every state change.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_bit_cnt <= '0;
      end else if (r_state == TX || r_state == RX) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Result is published on the edge that leaves DONE, together with the pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_result_valid <= (r_state == DONE);
      if (r_state == DONE) r_result <= w_rx_data;
    end
  end

`ifdef SHIFTER_TIMEOUT_EN
  // Counts WAIT_ACK cycles; the error pulse follows the abort edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (r_state == WAIT_ACK) r_to_cnt <= r_to_cnt + 1'b1;
      else                     r_to_cnt <= '0;
    end
  end
  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  // TX register: loaded at accept, so later input changes cannot reach the wire.
  shifter_spi_master_spi_shift_reg #(.WIDTH(PACKET_SIZE)) u_tx_reg (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_load_data (w_packet),
    .i_shift_en  (r_state == TX),
    .i_serial_in (1'b0),
    .o_data      (w_tx_data)
  );

  // RX register: shifts only in RX, so miso is never captured while nss is high.
  shifter_spi_master_spi_shift_reg #(.WIDTH(REGISTER_SIZE)) u_rx_reg (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_load_data ('0),
    .i_shift_en  (r_state == RX),
    .i_serial_in (i_miso),
    .o_data      (w_rx_data)
  );

  // Only bit 0 of the TX register is driven onto mosi.
  assign w_tx_unused = ^w_tx_data[PACKET_SIZE-1:1];

  assign w_link_active = (r_state == START) || (r_state == TX) ||
                         (r_state == WAIT_ACK) || (r_state == RX);

  for (genvar gi = 0; gi < NSS_WIDTH; gi++) begin : g_nss
    if (gi == NssPosition) begin : g_sel
      assign o_nss[gi] = ~w_link_active;
    end else begin : g_idle
      assign o_nss[gi] = 1'b1;
    end
  end

  assign o_mosi         = (r_state == START) | ((r_state == TX) & w_tx_data[0]);
  assign o_ready        = (r_state == IDLE);
  assign o_result_valid = r_result_valid;
  assign o_result       = r_result;

endmodule
